scoreboard_ctrl: RTL and testbench

- Sequential score/lives controller for the brick-smash game.
- Replaces hard-wired score0/score1/lives constants with registered, multi-player BCD state that feeds the scoreboard graphics generator.
- Accepts point-add requests (handshaked) and ball-lost events; handles BCD carry ripple, extra lives, player rotation, game over and a persistent high score.

---
 rtl/scoreboard_ctrl.sv | 155 +++++++++++++++
 tb/tb_scoreboard_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_ctrl.sv
// Score/lives controller for the brick-smash scoreboard: per-player BCD scores,
// lives with extra-life award, round-robin player rotation and a persistent high score.
module scoreboard_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 4,
  parameter int START_LIVES = 3,
  parameter int LIVES_W     = 4,
  parameter int EXTRA_DIGIT = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            new_game,
  input  logic                            add_valid,
  input  logic [3:0]                      add_pts,
  output logic                            add_ready,
  input  logic                            ball_lost,
  output logic [1:0]                      player,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] scores,
  output logic [NUM_PLAYERS*LIVES_W-1:0]  lives,
  output logic [DIGITS*4-1:0]             hi_score,
  output logic                            busy,
  output logic                            game_over
);

  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit EXTRA_EN  = (EXTRA_DIGIT > 0) && (EXTRA_DIGIT < DIGITS);
  localparam int EXTRA_IDX = (EXTRA_DIGIT > 0) ? EXTRA_DIGIT - 1 : 0;
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);

  typedef enum logic [2:0] {IDLE, ADD, LOSE, HISCAN, OVER} state_t;

  state_t                                state_q, state_nx;
  logic [NUM_PLAYERS-1:0][DIGITS-1:0][3:0] score_q;
  logic [NUM_PLAYERS-1:0][LIVES_W-1:0]   lives_q, lives_dec;
  logic [DIGITS*4-1:0]                   hi_q;
  logic [PW-1:0]                         player_q, scan_q, next_player, cand;
  logic [DW-1:0]                         idx_q;
  logic [3:0]                            pts_q, cur_digit, addend, new_digit;
  logic [4:0]                            sum;
  logic carry_q, pending_q, busy_q, over_q;
  logic carry_nx, add_last, top_ovf, extra_life, all_dead, found, scan_last;

  // One BCD digit per ADD cycle; digit 0 takes the points, higher digits the carry.
  always_comb begin
    cur_digit  = score_q[player_q][idx_q];
    addend     = (idx_q == '0) ? pts_q : {3'b000, carry_q};
    sum        = {1'b0, cur_digit} + {1'b0, addend};
    carry_nx   = (sum > 5'd9);
    new_digit  = carry_nx ? 4'(sum - 5'd10) : sum[3:0];
    add_last   = !carry_nx || (idx_q == DW'(DIGITS - 1));
    top_ovf    = carry_nx && (idx_q == DW'(DIGITS - 1));
    extra_life = EXTRA_EN && carry_nx && (idx_q == DW'(EXTRA_IDX));
    scan_last  = (scan_q == PW'(NUM_PLAYERS - 1));
  end

  // Rotation looks at lives after this LOSE's decrement, starting one past the
  // current player and wrapping back to it last.
  always_comb begin
    lives_dec = lives_q;
    if (lives_q[player_q] != '0)
      lives_dec[player_q] = lives_q[player_q] - 1'b1;
    found       = 1'b0;
    cand        = '0;
    next_player = player_q;
    for (int unsigned k = 1; k <= NUM_PLAYERS; k++) begin
      cand = PW'((32'(player_q) + k) % NUM_PLAYERS);
      if (!found && lives_dec[cand] != '0) begin
        found       = 1'b1;
        next_player = cand;
      end
    end
    all_dead = !found;
  end

  always_comb begin
    state_nx = state_q;
    if (new_game) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ball_lost || pending_q) state_nx = LOSE;
                 else if (add_valid)         state_nx = ADD;
        ADD:     if (add_last) state_nx = (pending_q || ball_lost) ? LOSE : IDLE;
        LOSE:    state_nx = all_dead ? HISCAN : IDLE;
        HISCAN:  if (scan_last) state_nx = OVER;
        default: state_nx = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      score_q   <= '0;
      lives_q   <= {NUM_PLAYERS{LIVES_INIT}};
      hi_q      <= '0;
      player_q  <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      pts_q     <= '0;
      carry_q   <= 1'b0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q <= state_nx;
      busy_q  <= (state_nx != IDLE);
      over_q  <= (state_nx == OVER);
      if (new_game) begin
        score_q   <= '0;
        lives_q   <= {NUM_PLAYERS{LIVES_INIT}};
        player_q  <= '0;
        pending_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (!(ball_lost || pending_q) && add_valid) begin
            pts_q   <= (add_pts > 4'd9) ? 4'd9 : add_pts;
            idx_q   <= '0;
            carry_q <= 1'b0;
          end
          ADD: begin
            score_q[player_q][idx_q] <= new_digit;
            if (top_ovf) score_q[player_q] <= {DIGITS{4'd9}};
            carry_q <= carry_nx;
            idx_q   <= idx_q + 1'b1;
            if (extra_life && lives_q[player_q] != '1)
              lives_q[player_q] <= lives_q[player_q] + 1'b1;
            if (ball_lost) pending_q <= 1'b1;
          end
          LOSE: begin
            pending_q <= 1'b0;
            lives_q   <= lives_dec;
            scan_q    <= '0;
            if (!all_dead) player_q <= next_player;
          end
          HISCAN: begin
            if (score_q[scan_q] > hi_q) hi_q <= score_q[scan_q];
            scan_q <= scan_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign add_ready = (state_q == IDLE) && !pending_q;
  assign player    = 2'(player_q);
  assign scores    = score_q;
  assign lives     = lives_q;
  assign hi_score  = hi_q;
  assign busy      = busy_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl (2 players, 4 digits, 3 lives, extra life at 1000s).
module tb_scoreboard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        new_game = 1'b0;
  logic        add_valid = 1'b0;
  logic        ball_lost = 1'b0;
  logic [3:0]  add_pts = 4'd0;
  logic        add_ready, busy, game_over;
  logic [1:0]  player;
  logic [31:0] scores;
  logic [7:0]  lives;
  logic [15:0] hi_score;

  int errors = 0;
  int checks = 0;
  int c;

  scoreboard_ctrl #(
    .NUM_PLAYERS(2), .DIGITS(4), .START_LIVES(3), .LIVES_W(4), .EXTRA_DIGIT(3)
  ) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .add_valid(add_valid),
    .add_pts(add_pts), .add_ready(add_ready), .ball_lost(ball_lost),
    .player(player), .scores(scores), .lives(lives), .hi_score(hi_score),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one add and return the number of busy cycles seen after acceptance.
  task automatic add_req(input logic [3:0] pts, output int cyc);
    int w = 0;
    while (!add_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!add_ready) check("add_ready_wait", add_ready, 1);
    add_valid = 1'b1;
    add_pts   = pts;
    @(negedge clk);
    add_valid = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    if (busy) check("busy_timeout", busy, 0);
  endtask

  task automatic lose();
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] exp_lives [4] = '{8'h22, 8'h21, 8'h11, 8'h10};
    logic [1:0] exp_plyr  [4] = '{2'd0, 2'd1, 2'd0, 2'd1};

    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_scores", scores, 32'h0);
    check("rst_lives", lives, 8'h33);
    check("rst_hi", hi_score, 16'h0);
    check("rst_player", player, 0);
    check("rst_ready", add_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_over", game_over, 0);

    add_req(4'd7, c);
    check("add7_lat", c, 1);
    add_req(4'd5, c);
    check("add5_lat", c, 2);
    check("score_12", scores, 32'h0000_0012);
    check("lives_12", lives, 8'h33);

    for (int i = 0; i < 109; i++) add_req(4'd9, c);
    add_req(4'd5, c);
    check("score_998", scores, 32'h0000_0998);
    add_req(4'd5, c);
    check("add_1003_lat", c, 4);
    check("score_1003", scores, 32'h0000_1003);
    check("lives_extra", lives, 8'h34);

    for (int i = 0; i < 999; i++) add_req(4'd9, c);
    add_req(4'd4, c);
    check("score_9998", scores, 32'h0000_9998);
    check("lives_9998", lives, 8'h3C);
    add_req(4'd9, c);
    check("sat_lat", c, 4);
    check("score_sat", scores, 32'h0000_9999);
    check("lives_sat", lives, 8'h3D);
    check("sat_idle", busy, 0);

    pulse_new_game();
    check("ng1_scores", scores, 32'h0);
    check("ng1_lives", lives, 8'h33);
    check("ng1_player", player, 0);
    for (int i = 0; i < 10; i++) add_req(4'hF, c);
    add_req(4'd5, c);
    check("clamp_95", scores, 32'h0000_0095);

    // Ball lost during a 3-digit ripple: add finishes, then LOSE.
    add_valid = 1'b1;
    add_pts   = 4'd5;
    @(negedge clk);
    add_valid = 1'b0;
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
    check("pend_ready", add_ready, 0);
    c = 2;
    while (c < 20) begin
      @(negedge clk);
      if (!busy) break;
      c++;
    end
    check("pend_busy_cyc", c, 4);
    check("pend_score", scores, 32'h0000_0100);
    check("pend_lives", lives, 8'h32);
    check("pend_player", player, 1);
    check("pend_ready_back", add_ready, 1);

    for (int i = 0; i < 5; i++) add_req(4'd9, c);
    check("p1_score", scores, 32'h0045_0100);

    for (int i = 0; i < 4; i++) begin
      lose();
      check($sformatf("lose%0d_lives", i), lives, exp_lives[i]);
      check($sformatf("lose%0d_player", i), player, exp_plyr[i]);
    end
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
    @(negedge clk);
    check("dead_lives", lives, 8'h00);
    check("scan_busy", busy, 1);
    check("scan_not_over", game_over, 0);
    c = 0;
    while (!game_over && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("scan_cycles", c, 2);
    check("hi_max", hi_score, 16'h0100);
    check("over_ready", add_ready, 0);

    add_valid = 1'b1;
    add_pts   = 4'd9;
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
    repeat (2) @(negedge clk);
    add_valid = 1'b0;
    check("over_scores", scores, 32'h0045_0100);
    check("over_hold", game_over, 1);
    check("over_lives", lives, 8'h00);

    pulse_new_game();
    check("ng2_scores", scores, 32'h0);
    check("ng2_lives", lives, 8'h33);
    check("ng2_hi", hi_score, 16'h0100);
    check("ng2_over", game_over, 0);
    check("ng2_busy", busy, 0);
    check("ng2_player", player, 0);
    check("ng2_ready", add_ready, 1);

    for (int i = 0; i < 15; i++) add_req(4'd9, c);
    check("score_135", scores, 32'h0000_0135);
    for (int i = 0; i < 5; i++) lose();
    check("pre_scan_lives", lives, 8'h10);
    ball_lost = 1'b1;
    @(negedge clk);
    ball_lost = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_scan_hi", hi_score, 16'h0135);
    #1 reset = 1'b0;
    #1;
    check("arst_scores", scores, 32'h0);
    check("arst_lives", lives, 8'h33);
    check("arst_hi", hi_score, 16'h0);
    check("arst_player", player, 0);
    check("arst_busy", busy, 0);
    check("arst_over", game_over, 0);
    check("arst_ready", add_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_hi", hi_score, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
